// File: rtl/tlul_host_engine.sv
// TL-UL host engine: turns single-word local commands into A-channel requests and
// returns the matching D-channel response, with a response timeout and late-beat drop.
module tlul_host_engine #(
    parameter int TL_AW     = 32,
    parameter int TL_DW     = 64,
    parameter int TL_AIW    = 8,
    parameter int TL_SZW    = 2,
    parameter int TL_DIW    = 1,
    parameter int SOURCE_ID = 0,
    parameter int TIMEOUT   = 256,
    localparam int TL_DBW   = TL_DW / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [TL_AW-1:0]  cmd_addr,
    input  logic [TL_DW-1:0]  cmd_wdata,
    input  logic [TL_DBW-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TL_DW-1:0]  rsp_rdata,
    output logic              rsp_error,
    output logic [2:0]        master_a_opcode,
    output logic [2:0]        master_a_param,
    output logic [TL_SZW-1:0] master_a_size,
    output logic [TL_AIW-1:0] master_a_source,
    output logic [TL_AW-1:0]  master_a_address,
    output logic [TL_DBW-1:0] master_a_mask,
    output logic [TL_DW-1:0]  master_a_data,
    output logic              master_a_corrupt,
    output logic              master_a_valid,
    input  logic              master_a_ready,
    input  logic [2:0]        master_d_opcode,
    input  logic [2:0]        master_d_param,
    input  logic [TL_SZW-1:0] master_d_size,
    input  logic [TL_AIW-1:0] master_d_source,
    input  logic [TL_DIW-1:0] master_d_sink,
    input  logic              master_d_denied,
    input  logic [TL_DW-1:0]  master_d_data,
    input  logic              master_d_corrupt,
    input  logic              master_d_valid,
    output logic              master_d_ready
);

    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t      state;
    logic        is_read;
    logic        stale;
    logic [15:0] tmo_cnt;
    logic        d_match;
    logic        stale_drop;
    logic        stale_ok;
    logic        d_err;
    logic        unused_d;

    assign master_a_param   = 3'b000;
    assign master_a_corrupt = 1'b0;
    assign unused_d         = ^{master_d_param, master_d_size, master_d_sink};

    always_comb begin
        d_match    = master_d_valid && master_d_ready &&
                     (master_d_source == TL_AIW'(SOURCE_ID));
        stale_drop = stale && d_match;
        stale_ok   = !stale || stale_drop;
        d_err      = master_d_denied || master_d_corrupt ||
                     (master_d_opcode != (is_read ? OP_ACK_DATA : OP_ACK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cmd_ready        <= 1'b0;
            master_a_valid   <= 1'b0;
            master_a_opcode  <= '0;
            master_a_size    <= '0;
            master_a_source  <= '0;
            master_a_address <= '0;
            master_a_mask    <= '0;
            master_a_data    <= '0;
            master_d_ready   <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_error        <= 1'b0;
            is_read          <= 1'b0;
            stale            <= 1'b0;
            tmo_cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= stale_ok;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        is_read   <= !cmd_write;
                        if (cmd_addr[2:0] != 3'b000) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state            <= REQ;
                            master_a_valid   <= 1'b1;
                            master_a_opcode  <= !cmd_write ? OP_GET :
                                                (&cmd_mask ? OP_PUT_FULL : OP_PUT_PARTIAL);
                            master_a_size    <= TL_SZW'($clog2(TL_DBW));
                            master_a_source  <= TL_AIW'(SOURCE_ID);
                            master_a_address <= cmd_addr;
                            master_a_mask    <= cmd_write ? cmd_mask : '1;
                            master_a_data    <= cmd_write ? cmd_wdata : '0;
                        end
                    end
                end
                REQ: begin
                    if (master_a_ready) begin
                        master_a_valid <= 1'b0;
                        master_d_ready <= 1'b1;
                        tmo_cnt        <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    // A match in the timeout cycle takes priority over the timeout.
                    if (d_match) begin
                        state          <= RSP;
                        master_d_ready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_error      <= d_err;
                        rsp_rdata      <= (is_read && !d_err) ? master_d_data : '0;
                    end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                        stale     <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                        cmd_ready <= stale_ok;
                    end
                end
                default: state <= IDLE;
            endcase
            // The late beat of a timed-out request is swallowed here, never reported.
            if (stale_drop) begin
                stale          <= 1'b0;
                master_d_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tlul_host_engine.sv
// Directed testbench for tlul_host_engine with a hand-driven TL-UL responder.
module tb_tlul_host_engine;
    localparam int AW = 32, DW = 64, DBW = 8, AIW = 8, SZW = 2, DIW = 1;
    localparam int SRC = 0, TMO = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_wdata;
    logic [DBW-1:0] cmd_mask;
    logic           rsp_valid, rsp_ready, rsp_error;
    logic [DW-1:0]  rsp_rdata;
    logic [2:0]     a_opcode, a_param;
    logic [SZW-1:0] a_size;
    logic [AIW-1:0] a_source;
    logic [AW-1:0]  a_address;
    logic [DBW-1:0] a_mask;
    logic [DW-1:0]  a_data;
    logic           a_corrupt, a_valid, a_ready;
    logic [2:0]     d_opcode, d_param;
    logic [SZW-1:0] d_size;
    logic [AIW-1:0] d_source;
    logic [DIW-1:0] d_sink;
    logic           d_denied, d_corrupt, d_valid, d_ready;
    logic [DW-1:0]  d_data;

    int n_checks = 0;
    int n_fail = 0;

    tlul_host_engine #(.TL_AW(AW), .TL_DW(DW), .TL_AIW(AIW), .TL_SZW(SZW), .TL_DIW(DIW),
                       .SOURCE_ID(SRC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .master_a_opcode(a_opcode), .master_a_param(a_param), .master_a_size(a_size),
        .master_a_source(a_source), .master_a_address(a_address), .master_a_mask(a_mask),
        .master_a_data(a_data), .master_a_corrupt(a_corrupt), .master_a_valid(a_valid),
        .master_a_ready(a_ready),
        .master_d_opcode(d_opcode), .master_d_param(d_param), .master_d_size(d_size),
        .master_d_source(d_source), .master_d_sink(d_sink), .master_d_denied(d_denied),
        .master_d_data(d_data), .master_d_corrupt(d_corrupt), .master_d_valid(d_valid),
        .master_d_ready(d_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DBW-1:0] mask);
        int i;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_mask = mask; cmd_valid = 1'b1;
        i = 0;
        while (!cmd_ready && i < 1000) begin tick(); i++; end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic accept_a();
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [AIW-1:0] src,
                          input logic den, input logic cor, input logic [DW-1:0] data);
        d_opcode = op; d_source = src; d_denied = den; d_corrupt = cor; d_data = data;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0; d_data = '0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({cmd_ready, a_valid, d_ready, rsp_valid, rsp_error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/av/dr/rv/re=%b required 00000",
                     {cmd_ready, a_valid, d_ready, rsp_valid, rsp_error});
        end
        n_checks++;
        if ({a_opcode, a_size, a_address, a_mask, a_data, rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: A/rsp data fields not zero");
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_full();
        issue(1'b1, 32'h8, 64'h1122334455667788, 8'hFF);
        n_checks++;
        if ({a_valid, a_opcode, a_size, a_source, a_param, a_corrupt} !== {1'b1, 3'd0, 2'd3, 8'd0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_a_ctrl: got v=%b op=%0d sz=%0d src=%0d required v=1 op=0 sz=3 src=0",
                     a_valid, a_opcode, a_size, a_source);
        end
        n_checks++;
        if ({a_address, a_data, a_mask} !== {32'h8, 64'h1122334455667788, 8'hFF}) begin
            n_fail++;
            $display("FAIL wr_a_data: got addr=%h data=%h mask=%h", a_address, a_data, a_mask);
        end
        accept_a();
        n_checks++;
        if ({a_valid, d_ready} !== 2'b01) begin
            n_fail++; $display("FAIL wr_wait: a_valid/d_ready=%b required 01", {a_valid, d_ready});
        end
        d_beat(3'd0, 8'(SRC), 1'b0, 1'b0, 64'h0);
        n_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, d_ready} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_rsp: got v=%b e=%b d=%h dr=%b required v=1 e=0 d=0 dr=0",
                     rsp_valid, rsp_error, rsp_rdata, d_ready);
        end
        take_rsp();
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL wr_back_to_back: rsp_valid/cmd_ready=%b required 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read();
        issue(1'b0, 32'h8, 64'h0, 8'h00);
        n_checks++;
        if ({a_valid, a_opcode, a_mask} !== {1'b1, 3'd4, 8'hFF}) begin
            n_fail++;
            $display("FAIL rd_a: got v=%b op=%0d mask=%h required v=1 op=4 mask=ff",
                     a_valid, a_opcode, a_mask);
        end
        accept_a();
        d_beat(3'd1, 8'(SRC), 1'b0, 1'b0, 64'h1122334455667788);
        n_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 64'h1122334455667788}) begin
            n_fail++;
            $display("FAIL rd_rsp: got v=%b e=%b d=%h required v=1 e=0 d=1122334455667788",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_partial_write();
        issue(1'b1, 32'h10, 64'hDEADBEEFCAFEF00D, 8'h0F);
        n_checks++;
        if ({a_opcode, a_mask} !== {3'd1, 8'h0F}) begin
            n_fail++; $display("FAIL pw_a: got op=%0d mask=%h required op=1 mask=0f", a_opcode, a_mask);
        end
        accept_a();
        d_beat(3'd0, 8'(SRC), 1'b0, 1'b0, 64'h0);
        n_checks++;
        if ({rsp_valid, rsp_error} !== 2'b10) begin
            n_fail++; $display("FAIL pw_rsp: valid/error=%b required 10", {rsp_valid, rsp_error});
        end
        take_rsp();
    endtask

    task automatic test_a_stall();
        issue(1'b1, 32'h40, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({a_valid, d_ready, a_opcode, a_address, a_data} !==
                {1'b1, 1'b0, 3'd0, 32'h40, 64'hA5A5_5A5A_0F0F_F0F0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: v=%b dr=%b op=%0d addr=%h data=%h",
                         i, a_valid, d_ready, a_opcode, a_address, a_data);
            end
        end
        accept_a();
        d_beat(3'd0, 8'h05, 1'b0, 1'b0, 64'h0);
        n_checks++;
        if ({rsp_valid, d_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL wrong_source: rsp_valid/d_ready=%b required 01", {rsp_valid, d_ready});
        end
        d_beat(3'd0, 8'(SRC), 1'b0, 1'b0, 64'h0);
        n_checks++;
        if ({rsp_valid, rsp_error} !== 2'b10) begin
            n_fail++; $display("FAIL stall_rsp: valid/error=%b required 10", {rsp_valid, rsp_error});
        end
        take_rsp();
    endtask

    task automatic test_misaligned();
        issue(1'b0, 32'hC, 64'h0, 8'h00);
        n_checks++;
        if ({a_valid, rsp_valid, rsp_error, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL misaligned: got av=%b rv=%b re=%b d=%h required av=0 rv=1 re=1 d=0",
                     a_valid, rsp_valid, rsp_error, rsp_rdata);
        end
        take_rsp();
        n_checks++;
        if (a_valid !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_no_a: a_valid=%b required 0", a_valid);
        end
    endtask

    task automatic test_errors();
        issue(1'b0, 32'h18, 64'h0, 8'h00);
        accept_a();
        d_beat(3'd1, 8'(SRC), 1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000);
        n_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL denied: got v=%b e=%b d=%h required v=1 e=1 d=0", rsp_valid, rsp_error, rsp_rdata);
        end
        take_rsp();
        issue(1'b0, 32'h20, 64'h0, 8'h00);
        accept_a();
        d_beat(3'd0, 8'(SRC), 1'b0, 1'b0, 64'h1234);
        n_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL opcode_mismatch: got v=%b e=%b d=%h required v=1 e=1 d=0",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b1, 32'h28, 64'h77, 8'hFF);
        accept_a();
        n = 0;
        while (!rsp_valid && n < 400) begin tick(); n++; end
        n_checks++;
        if (n !== TMO) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles required %0d", n, TMO);
        end
        n_checks++;
        if ({rsp_valid, rsp_error, cmd_ready, d_ready} !== 4'b1101) begin
            n_fail++;
            $display("FAIL timeout_rsp: v/e/cr/dr=%b required 1101", {rsp_valid, rsp_error, cmd_ready, d_ready});
        end
        take_rsp();
        tick(); tick();
        n_checks++;
        if ({cmd_ready, d_ready, rsp_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL stale_block: cr/dr/rv=%b required 010", {cmd_ready, d_ready, rsp_valid});
        end
        d_beat(3'd0, 8'(SRC), 1'b0, 1'b0, 64'h0);
        n_checks++;
        if ({cmd_ready, d_ready, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL stale_drop: cr/dr/rv=%b required 100", {cmd_ready, d_ready, rsp_valid});
        end
        issue(1'b0, 32'h30, 64'h0, 8'h00);
        accept_a();
        d_beat(3'd1, 8'(SRC), 1'b0, 1'b0, 64'h0BAD_F00D_1357_9BDF);
        n_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 64'h0BAD_F00D_1357_9BDF}) begin
            n_fail++;
            $display("FAIL after_timeout: got v=%b e=%b d=%h", rsp_valid, rsp_error, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_rsp_hold();
        issue(1'b0, 32'h38, 64'h0, 8'h00);
        accept_a();
        d_beat(3'd1, 8'(SRC), 1'b0, 1'b0, 64'hFEDC_BA98_7654_3210);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 64'hFEDC_BA98_7654_3210}) begin
                n_fail++;
                $display("FAIL rsp_hold[%0d]: got v=%b e=%b d=%h", i, rsp_valid, rsp_error, rsp_rdata);
            end
        end
        take_rsp();
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rsp_release: rv/cr=%b required 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_reset_mid_wait();
        issue(1'b1, 32'h48, 64'h99, 8'hFF);
        accept_a();
        tick(); tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({cmd_ready, a_valid, d_ready, rsp_valid, rsp_error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: cr/av/dr/rv/re=%b required 00000",
                     {cmd_ready, a_valid, d_ready, rsp_valid, rsp_error});
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({cmd_ready, d_ready, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_recover: cr/dr/rv=%b required 100", {cmd_ready, d_ready, rsp_valid});
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        rsp_ready = 1'b0; a_ready = 1'b0;
        d_opcode = '0; d_param = '0; d_size = '0; d_source = '0; d_sink = '0;
        d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0; d_valid = 1'b0;
        test_reset();
        test_write_full();
        test_read();
        test_partial_write();
        test_a_stall();
        test_misaligned();
        test_errors();
        test_timeout();
        test_rsp_hold();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
